// File: rtl/sc_stream_seq.sv
// sc_stream_seq -- sequencer for one stochastic-computing stream.
//
// A start request in IDLE samples seed, comparator operand and stream length.
// One LOAD cycle primes the LFSR and clears the ones counter while the
// external datapath is held cleared. RUN then steps the 8-bit LFSR once per
// cycle for exactly 'length' cycles, counting the datapath's stochastic
// output bits. The count is presented in DONE until it is accepted.
//
// The reset input rst_n is asynchronous and ACTIVE-HIGH despite its name.
//
// Optional feature macro: SC_SEQ_ZERO_SEED_FIX_EN
//   defined   : a sampled seed of 8'h00 is replaced by 8'h01 when loaded,
//               so the LFSR never sits in its all-zero lock-up state.
//   undefined : the seed is used as given (seed 0 keeps dp_s at 0).

module sc_stream_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       cfg_seed,
    input  logic [7:0]       cfg_b,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic [7:0]       dp_s,
    output logic [7:0]       dp_b,
    output logic             dp_clr,
    output logic             dp_x1_o,
    output logic             dp_x2_o,
    input  logic             dp_x1_i,
    input  logic             dp_x2_i,
    input  logic             dp_bit,
    output logic [LEN_W:0]   res_count,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_reg;
    logic [7:0]       seed_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W:0]   cnt_reg;
    logic [LEN_W:0]   ones_reg;
    logic [7:0]       dp_s_reg;
    logic [7:0]       dp_b_reg;
    logic             dp_clr_reg;
    logic             busy_reg;
    logic             res_valid_reg;
    logic [LEN_W:0]   res_count_reg;

    logic [7:0]       lfsr_next;
    logic [7:0]       seed_load;
    logic [LEN_W:0]   len_cycles;
    logic [LEN_W:0]   ones_next;
    logic             last_run;
    logic             run_flag;

    // LFSR step: shift right by one, new MSB is the tap parity s6^s5^s4^s0.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = dp_s_reg[gi+1];
        end
    endgenerate
    assign lfsr_next[7] = dp_s_reg[6] ^ dp_s_reg[5] ^ dp_s_reg[4] ^ dp_s_reg[0];

`ifdef SC_SEQ_ZERO_SEED_FIX_EN
    // The all-zero state is a fixed point of the LFSR, so steer away from it.
    assign seed_load = (seed_reg == 8'h00) ? 8'h01 : seed_reg;
`else
    assign seed_load = seed_reg;
`endif

    // A length field of zero encodes the maximum stream of 2^LEN_W cycles.
    assign len_cycles = (len_reg == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_reg};

    // Count including the bit presented this cycle; cannot exceed the length.
    assign ones_next = ones_reg + {{LEN_W{1'b0}}, dp_bit};

    // The cycle counter reaching one marks the final RUN cycle.
    assign last_run = (cnt_reg == {{LEN_W{1'b0}}, 1'b1});

    assign run_flag = (state_reg == ST_RUN);

    // Main sequencer: state, LFSR, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg     <= ST_IDLE;
            seed_reg      <= 8'h00;
            len_reg       <= '0;
            cnt_reg       <= '0;
            ones_reg      <= '0;
            dp_s_reg      <= 8'h00;
            dp_b_reg      <= 8'h00;
            dp_clr_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            res_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        seed_reg  <= cfg_seed;
                        len_reg   <= cfg_len;
                        dp_b_reg  <= cfg_b;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dp_s_reg   <= seed_load;
                    cnt_reg    <= len_cycles;
                    ones_reg   <= '0;
                    dp_clr_reg <= 1'b0;
                    state_reg  <= ST_RUN;
                end
                ST_RUN: begin
                    ones_reg <= ones_next;
                    dp_s_reg <= lfsr_next;
                    cnt_reg  <= cnt_reg - {{LEN_W{1'b0}}, 1'b1};
                    if (last_run) begin
                        res_count_reg <= ones_next;
                        res_valid_reg <= 1'b1;
                        dp_clr_reg    <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here; it only
                    // counts once the sequencer is back in IDLE.
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Feedback bits pass straight through while running, so the datapath
    // sees its own outputs in the same cycle; outside RUN they are held low.
    assign dp_x1_o = run_flag & dp_x1_i;
    assign dp_x2_o = run_flag & dp_x2_i;

    assign busy      = busy_reg;
    assign dp_s      = dp_s_reg;
    assign dp_b      = dp_b_reg;
    assign dp_clr    = dp_clr_reg;
    assign res_count = res_count_reg;
    assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_sc_stream_seq.sv
// Bench for sc_stream_seq: random streams against a transaction-level model
// (cycles elapsed since start acceptance), plus directed literal checks.
module tb_sc_stream_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       cfg_seed = 8'h00;
    logic [7:0]       cfg_b = 8'h00;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy;
    logic [7:0]       dp_s;
    logic [7:0]       dp_b;
    logic             dp_clr;
    logic             dp_x1_o;
    logic             dp_x2_o;
    logic             dp_x1_i = 1'b0;
    logic             dp_x2_i = 1'b0;
    logic             dp_bit = 1'b0;
    logic [LEN_W:0]   res_count;
    logic             res_valid;
    logic             res_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int bit_mode = 0;  // 0 random, 1 all ones, 2 all zeros

    sc_stream_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_seed(cfg_seed), .cfg_b(cfg_b), .cfg_len(cfg_len),
        .busy(busy), .dp_s(dp_s), .dp_b(dp_b), .dp_clr(dp_clr),
        .dp_x1_o(dp_x1_o), .dp_x2_o(dp_x2_o),
        .dp_x1_i(dp_x1_i), .dp_x2_i(dp_x2_i), .dp_bit(dp_bit),
        .res_count(res_count), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] lfsr_n(input logic [7:0] s0, input int n);
        logic [7:0] s;
        s = s0;
        for (int i = 0; i < n; i++) s = {s[6] ^ s[5] ^ s[4] ^ s[0], s[7:1]};
        return s;
    endfunction

    function automatic logic [7:0] eff_seed(input logic [7:0] s);
`ifdef SC_SEQ_ZERO_SEED_FIX_EN
        return (s == 8'h00) ? 8'h01 : s;
`else
        return s;
`endif
    endfunction

    // m_k counts cycles since acceptance: 1 = load, 2..L+1 = run, >L+1 = done
    bit             m_active;
    bit             m_fresh;
    int             m_k;
    int             m_len;
    int             m_ones;
    logic [7:0]     m_seed;
    logic [7:0]     m_b;
    logic [LEN_W:0] m_res;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_active = 1'b0; m_fresh = 1'b1; m_k = 0; m_len = 1; m_ones = 0;
            m_seed = 8'h00; m_b = 8'h00; m_res = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_fresh = 1'b0; m_k = 1; m_ones = 0;
                m_len = (cfg_len == '0) ? (1 << LEN_W) : int'(cfg_len);
                m_seed = eff_seed(cfg_seed);
                m_b = cfg_b;
            end
        end else begin
            if (m_k >= 2 && m_k <= m_len + 1) m_ones += int'(dp_bit);
            if (m_k >= m_len + 2 && res_ready) m_active = 1'b0;
            else begin
                m_k++;
                if (m_k == m_len + 2) m_res = (LEN_W+1)'(m_ones);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit run;
        run = m_active && m_k >= 2 && m_k <= m_len + 1;
        chk("busy", 32'(busy), 32'(m_active));
        chk("res_valid", 32'(res_valid), 32'(m_active && m_k >= m_len + 2));
        chk("dp_clr", 32'(dp_clr), 32'(!run));
        chk("dp_b", 32'(dp_b), 32'(m_b));
        chk("res_count", 32'(res_count), 32'(m_res));
        chk("dp_x1_o", 32'(dp_x1_o), run ? 32'(dp_x1_i) : 32'd0);
        chk("dp_x2_o", 32'(dp_x2_o), run ? 32'(dp_x2_i) : 32'd0);
        if (run) chk("dp_s", 32'(dp_s), 32'(lfsr_n(m_seed, m_k - 2)));
        else if (m_fresh && !m_active) chk("dp_s_idle", 32'(dp_s), 32'd0);
    endtask

    // One clock: compare on the falling edge, then drive new inputs just after the rise.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        case (bit_mode)
            1: dp_bit = 1'b1;
            2: dp_bit = 1'b0;
            default: dp_bit = 1'($urandom);
        endcase
        dp_x1_i = 1'($urandom);
        dp_x2_i = 1'($urandom);
    endtask

    task automatic run_stream(input logic [7:0] s, input logic [7:0] b,
                              input logic [LEN_W-1:0] l, input int rw,
                              output logic [LEN_W:0] cnt);
        int n;
        start = 1'b1; cfg_seed = s; cfg_b = b; cfg_len = l;
        step();
        start = 1'b0;
        cfg_seed = 8'($urandom); cfg_b = 8'($urandom); cfg_len = LEN_W'($urandom);
        n = 0;
        while (!res_valid && n < 400) begin
            res_ready = 1'($urandom);
            step();
            n++;
        end
        if (!res_valid) begin
            tests++; fails++;
            $display("FAIL stream_timeout: got res_valid=0 expected 1 after %0d cycles", n);
        end
        cnt = res_count;
        for (int i = 0; i < rw; i++) begin
            res_ready = 1'b0;
            start = 1'($urandom);
            step();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        // start coinciding with the handshake must be ignored
        res_ready = 1'b1; start = 1'b1;
        step();
        res_ready = 1'b0; start = 1'b0;
        chk("busy_after_hs", 32'(busy), 32'd0);
        $display("[TB] stream seed=%02h len=%0d count=%0d", s, l, cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [LEN_W:0] cnt;
        logic [7:0]     z0, z1;
        int             rs, rl;

        // reset state
        dp_x1_i = 1'b1;
        step();
        dp_x1_i = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_clr", 32'(dp_clr), 32'd1);
        chk("rst_dp_s", 32'(dp_s), 32'd0);
        chk("rst_dp_b", 32'(dp_b), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_dp_x1_o", 32'(dp_x1_o), 32'd0);
        rst_n = 1'b0;
        step();

        // seed 01, len 2: dp_s 01 then 80, result after two RUN cycles
        start = 1'b1; cfg_seed = 8'h01; cfg_b = 8'h33; cfg_len = 8'd2;
        step();
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_dp_clr", 32'(dp_clr), 32'd1);
        chk("load_dp_b", 32'(dp_b), 32'h33);
        step();
        chk("run0_dp_s", 32'(dp_s), 32'h01);
        chk("run0_dp_clr", 32'(dp_clr), 32'd0);
        dp_x1_i = 1'b1; #1;
        chk("run_x1_pass", 32'(dp_x1_o), 32'd1);
        step();
        chk("run1_dp_s", 32'(dp_s), 32'h80);
        step();
        chk("done_valid", 32'(res_valid), 32'd1);
        chk("done_dp_clr", 32'(dp_clr), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        dp_x1_i = 1'b1; #1;
        chk("idle_x1_block", 32'(dp_x1_o), 32'd0);

        // maximum-length stream with constant bits
        bit_mode = 1;
        run_stream(8'hA5, 8'h10, '0, 0, cnt);
        chk("ones_len0", 32'(cnt), 32'd256);
        bit_mode = 2;
        run_stream(8'h5C, 8'h20, '0, 0, cnt);
        chk("zeros_len0", 32'(cnt), 32'd0);
        bit_mode = 0;

        // result held for 10 cycles with start pulses
        run_stream(8'h3C, 8'hC3, 8'd5, 10, cnt);

        // zero seed
`ifdef SC_SEQ_ZERO_SEED_FIX_EN
        z0 = 8'h01; z1 = 8'h80;
`else
        z0 = 8'h00; z1 = 8'h00;
`endif
        start = 1'b1; cfg_seed = 8'h00; cfg_len = 8'd3;
        step();
        start = 1'b0;
        step();
        chk("zseed_run0", 32'(dp_s), 32'(z0));
        step();
        chk("zseed_run1", 32'(dp_s), 32'(z1));
        step();
        step();
        chk("zseed_done", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // reset in the middle of RUN
        start = 1'b1; cfg_seed = 8'h5A; cfg_len = 8'd16;
        step();
        start = 1'b0;
        repeat (6) step();
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dp_s", 32'(dp_s), 32'd0);
        chk("mid_rst_dp_b", 32'(dp_b), 32'd0);
        chk("mid_rst_dp_clr", 32'(dp_clr), 32'd1);
        chk("mid_rst_x1", 32'(dp_x1_o), 32'd0);
        chk("mid_rst_x2", 32'(dp_x2_o), 32'd0);
        chk("mid_rst_count", 32'(res_count), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_valid_after_rst", 32'(res_valid), 32'd0);
        end

        // randomized streams
        for (int t = 0; t < 25; t++) begin
            rs = $urandom_range(0, 7);
            rl = (rs == 0) ? 0 : $urandom_range(1, 30);
            run_stream(8'($urandom), 8'($urandom), LEN_W'(rl), $urandom_range(0, 3), cnt);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_stream_seq.md
SC_STREAM_SEQ -- requirements
Module: sc_stream_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the stream-length field; maximum stream length is 2^LEN_W cycles.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset: asynchronous, active-high (asserted when 1).
REQ-004 start  input  1  request to run one stochastic stream; accepted only in IDLE.
REQ-005 cfg_seed  input  8  LFSR seed, sampled on start acceptance.
REQ-006 cfg_b  input  8  comparator operand, sampled on start acceptance.
REQ-007 cfg_len  input  LEN_W  stream length; 0 means 2^LEN_W cycles.
REQ-008 busy  output  1  high from start acceptance until the result is taken.
REQ-009 dp_s  output  8  LFSR state driven to the datapath input_s.
REQ-010 dp_b  output  8  registered copy of cfg_b, driven to the datapath input_b.
REQ-011 dp_clr  output  1  high clears the datapath flops (drives the datapath reset pin); low lets them run.
REQ-012 dp_x1_o, dp_x2_o  output  1 each  feedback bits driven to datapath in_x_1/in_x_2.
REQ-013 dp_x1_i, dp_x2_i  input  1 each  datapath out_x_1/out_x_2.
REQ-014 dp_bit  input  1  datapath output_circuit stochastic bit.
REQ-015 res_count  output  LEN_W+1  number of 1 bits counted over the stream.
REQ-016 res_valid / res_ready  output / input  1 each  result handshake.

Function
REQ-017 FSM states IDLE, LOAD, RUN, DONE; encoding is free.
REQ-018 IDLE: start=1 -> LOAD; seed, b and length registered, busy rises next cycle; start in any other state ignored.
REQ-019 LOAD (1 cycle): dp_s=seed, cycle counter = length, ones counter = 0, dp_clr=1 -> RUN.
REQ-020 RUN: dp_clr=0; each cycle ones counter += dp_bit; dp_s <= {s6^s5^s4^s0, s7..s1}; counter decrements.
REQ-021 dp_x1_o/dp_x2_o = dp_x1_i/dp_x2_i in RUN, forced 0 otherwise.
REQ-022 RUN lasts exactly length cycles (cfg_len=0 -> 2^LEN_W); then -> DONE with res_count = final ones count.
REQ-023 DONE: res_valid=1, res_count stable, dp_clr=1; res_valid&res_ready -> IDLE next cycle, busy falls.
REQ-024 Ones counter width LEN_W+1; cannot overflow since count <= length.
REQ-025 dp_b holds the sampled operand from LOAD until next start acceptance.
REQ-026 start asserted in the same cycle as the DONE handshake is ignored; it must be re-asserted in IDLE.

Reset
REQ-027 rst_n=1 asynchronously forces IDLE, dp_s=0, dp_b=0, dp_clr=1, dp_x*_o=0, res_count=0, res_valid=0, busy=0.
REQ-028 Reset during RUN or DONE abandons the stream; no result is produced; normal operation resumes on the first edge after release.

Configuration
REQ-029 Macro SC_SEQ_ZERO_SEED_FIX_EN defined: a sampled cfg_seed of 8'h00 is replaced by 8'h01 in LOAD (avoids the LFSR lock-up state).
REQ-030 Macro undefined: seed used as given; seed 0 yields a constant dp_s=0 for the whole stream.

Verification
REQ-031 Reset asserted mid-RUN (seed 8'h5A, len 16, after 5 cycles) -> all outputs at REQ-027 values immediately; no res_valid.
REQ-032 seed 8'h01, len 2 -> dp_s sequence 8'h01, 8'h80 in RUN; res_valid after 2 RUN cycles.
REQ-033 dp_bit tied 1, len 0, LEN_W=8 -> res_count=256; dp_bit tied 0 -> res_count=0.
REQ-034 res_ready held 0 for 10 cycles in DONE -> res_valid and res_count stable; start pulses ignored; busy stays 1.
REQ-035 seed 8'h00 with macro -> first RUN dp_s=8'h01; without macro -> dp_s=8'h00 throughout.
REQ-036 dp_x1_i=1 in IDLE -> dp_x1_o=0; in RUN -> dp_x1_o=1 same cycle.
